cordic_result_unfold: RTL
=========================

// Module: cordic_result_unfold
// PURPOSE
//  Output stage for the CORDIC pipeline. Takes the pipeline's first-quadrant
//  results (Q7.8 angle, x, y, sector, mode) and undoes the quadrant fold to
//  produce full-circle signed results. Buffers results in a FIFO with a
//  valid/ready handshake toward the consumer. The pipeline cannot stall, so
//  the block exports almost_full to gate issue and flags any dropped result.
// PARAMETERS
//  IN_WIDTH           16     unsigned Q7.8 width of degree_in/x_in/y_in
//  OUT_WIDTH          17     width of out_degree (unsigned Q9.8) and out_x/out_y (signed Q8.8)
//  SECTOR_FLAG_WIDTH  2      quadrant code width
//  FIFO_DEPTH         8      result entries, power of two, >= 2
//  ALMOST_FULL_LEVEL  6      almost_full asserts when count >= this
//  QUARTER_TURN       23040  90 degrees in Q.8 (0x5A00)
// PORTS
//  clk              in   1                    clock; all state updates on posedge
//  reset            in   1                    synchronous, active-low
//  valid_in         in   1                    pipeline result present this cycle
//  degree_in        in   IN_WIDTH             folded angle, Q7.8, range [0,90]
//  x_in, y_in       in   IN_WIDTH             folded x/y (or magnitude/residual), Q7.8
//  sector_in        in   SECTOR_FLAG_WIDTH    quadrant: 0=Q1 1=Q2 2=Q3 3=Q4
//  arctan_en_in     in   1                    1=vectoring result, 0=rotation result
//  out_valid        out  1                    FIFO head valid
//  out_ready        in   1                    consumer accepts head when out_valid&out_ready
//  out_degree       out  OUT_WIDTH            unfolded angle, Q9.8, [0,360)
//  out_x, out_y     out  OUT_WIDTH            unfolded coordinates, two's complement Q8.8
//  out_arctan       out  1                    mode of head entry
//  count            out  $clog2(FIFO_DEPTH)+1 FIFO occupancy
//  almost_full      out  1                    count >= ALMOST_FULL_LEVEL
//  overflow         out  1                    sticky: a result was dropped
//  clear_overflow   in   1                    clears overflow
// BEHAVIOUR
//  - Reset (reset==0 at posedge): out_valid=0, count=0, almost_full=0, overflow=0,
//    stage register invalid, FIFO pointers 0; out_degree/out_x/out_y/out_arctan=0.
//    Reset mid-operation discards all buffered and in-flight results.
//  - Stage 1 (registered, every cycle): captures valid_in and the unfolded result.
//    Zero-extend inputs to OUT_WIDTH; X=x_in, Y=y_in.
//    out_degree = degree_in + sector_in*QUARTER_TURN (both modes, no wrap needed).
//    Rotation (arctan_en_in=0): sector 0:(X,Y)  1:(-Y,X)  2:(-X,-Y)  3:(Y,-X).
//    Vectoring (arctan_en_in=1): x = X (magnitude), y = Y; no sign unfold.
//    Negation is two's complement in OUT_WIDTH; -0 yields 0.
//  - Stage 2: FIFO write of stage-1 entry when stage valid and (count<FIFO_DEPTH
//    or a read happens that cycle). Full with no read: entry dropped, overflow<=1.
//  - Read: pop when out_valid & out_ready. Head presented first-word-fall-through;
//    outputs stable while out_valid & !out_ready.
//  - Latency: valid_in at edge N -> stage at N+1 -> FIFO write at N+1 edge result
//    visible, out_valid=1 in cycle after edge N+2 (2 cycles); no empty bypass.
//  - Simultaneous read+write: count unchanged, legal at full and at count=1.
//  - Read when empty ignored. Pointers wrap modulo FIFO_DEPTH.
//  - overflow: set wins over clear_overflow in the same cycle; otherwise clear.
//  - count, almost_full registered, consistent with FIFO after each edge.
// TESTING
//  1 rot, sector=1, deg=0x1E00, x=0x0100, y=0 -> 2 cyc later out_degree=0x07800,
//    out_x=0x00000, out_y=0x00100, out_arctan=0.
//  2 rot, sector=2, deg=0x1E00, x=0x00DD, y=0x0080 -> out_degree=0x0D200,
//    out_x=0x1FF23, out_y=0x1FF80.
//  3 vec, sector=3, deg=0x2D00, x=0x016A, y=0x0003 -> out_degree=0x13B00,
//    out_x=0x0016A, out_y=0x00003, out_arctan=1.
//  4 out_ready=0, 10 back-to-back valid_in -> count=8, almost_full from count=6,
//    entries 9-10 dropped, overflow=1; then out_ready=1 drains entries 1-8 in order.
//  5 full FIFO, out_ready=1 with stage valid -> count stays 8, overflow stays 0.
//  6 5 entries buffered, reset low 1 cycle -> next cycle out_valid=0, count=0,
//    almost_full=0, overflow=0; clear_overflow with coincident drop keeps overflow=1.

Source files
------------

// File: rtl/cordic_result_unfold.sv
// CORDIC output stage: unfolds first-quadrant results to the full circle and
// buffers them in a first-word-fall-through FIFO with overflow reporting.
module cordic_result_unfold #(
   parameter int unsigned IN_WIDTH          = 16,
   parameter int unsigned OUT_WIDTH         = 17,
   parameter int unsigned SECTOR_FLAG_WIDTH = 2,
   parameter int unsigned FIFO_DEPTH        = 8,
   parameter int unsigned ALMOST_FULL_LEVEL = 6,
   parameter int unsigned QUARTER_TURN      = 23040
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           valid_in,
   input  logic [IN_WIDTH-1:0]            degree_in,
   input  logic [IN_WIDTH-1:0]            x_in,
   input  logic [IN_WIDTH-1:0]            y_in,
   input  logic [SECTOR_FLAG_WIDTH-1:0]   sector_in,
   input  logic                           arctan_en_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [OUT_WIDTH-1:0]           out_degree,
   output logic [OUT_WIDTH-1:0]           out_x,
   output logic [OUT_WIDTH-1:0]           out_y,
   output logic                           out_arctan,
   output logic [$clog2(FIFO_DEPTH):0]    count,
   output logic                           almost_full,
   output logic                           overflow,
   input  logic                           clear_overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic                 arctan;
      logic [OUT_WIDTH-1:0] degree;
      logic [OUT_WIDTH-1:0] x;
      logic [OUT_WIDTH-1:0] y;
   } entry_t;

   entry_t               stage_d_c;
   entry_t               stage_q;
   logic                 stage_valid;
   logic [OUT_WIDTH-1:0] xe_c;
   logic [OUT_WIDTH-1:0] ye_c;

   entry_t               mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic                 rd_en_c;
   logic                 wr_en_c;
   logic                 drop_c;
   logic [CW-1:0]        count_next_c;

   // Quadrant unfold of the incoming pipeline result
   always_comb begin
      xe_c             = OUT_WIDTH'(x_in);
      ye_c             = OUT_WIDTH'(y_in);
      stage_d_c        = '0;
      stage_d_c.arctan = arctan_en_in;
      stage_d_c.degree = OUT_WIDTH'(degree_in)
                       + OUT_WIDTH'(sector_in) * OUT_WIDTH'(QUARTER_TURN);
      stage_d_c.x      = xe_c;
      stage_d_c.y      = ye_c;
      if (!arctan_en_in) begin
         case (sector_in)
            SECTOR_FLAG_WIDTH'(1): begin
               stage_d_c.x = OUT_WIDTH'(0) - ye_c;
               stage_d_c.y = xe_c;
            end
            SECTOR_FLAG_WIDTH'(2): begin
               stage_d_c.x = OUT_WIDTH'(0) - xe_c;
               stage_d_c.y = OUT_WIDTH'(0) - ye_c;
            end
            SECTOR_FLAG_WIDTH'(3): begin
               stage_d_c.x = ye_c;
               stage_d_c.y = OUT_WIDTH'(0) - xe_c;
            end
            default: begin
               stage_d_c.x = xe_c;
               stage_d_c.y = ye_c;
            end
         endcase
      end
   end

   // FIFO control; a pop in the same cycle frees the slot for a write at full
   always_comb begin
      rd_en_c      = out_valid & out_ready;
      wr_en_c      = stage_valid & ((count < CW'(FIFO_DEPTH)) | rd_en_c);
      drop_c       = stage_valid & ~wr_en_c;
      count_next_c = count + CW'(wr_en_c) - CW'(rd_en_c);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stage_valid <= 1'b0;
         stage_q     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         out_valid   <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         stage_valid <= valid_in;
         stage_q     <= stage_d_c;
         if (wr_en_c) begin
            mem[wr_ptr] <= stage_q;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_en_c) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count       <= count_next_c;
         out_valid   <= (count_next_c != '0);
         almost_full <= (count_next_c >= CW'(ALMOST_FULL_LEVEL));
         if (drop_c) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   assign out_degree = mem[rd_ptr].degree;
   assign out_x      = mem[rd_ptr].x;
   assign out_y      = mem[rd_ptr].y;
   assign out_arctan = mem[rd_ptr].arctan;

endmodule
